// File: rtl/m68k_bus_master_pkg.sv
// m68k_bus_master_pkg: FSM state encodings, data-strobe lane masks and the latched request record
// shared by the 68000 bus-master slice.
`default_nettype none

package m68k_bus_master_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_STRB = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_TERM = 3'd5;

    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_WORD = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef struct packed {
        logic        rw;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [1:0]  lanes;   // {upper, lower}
    } bus_req_t;

    // No lane selected means a full word access.
    function automatic logic [1:0] lane_mask(input logic uds, input logic lds);
        return ({uds, lds} == LANE_NONE) ? LANE_WORD : {uds, lds};
    endfunction

endpackage

`default_nettype wire

// File: rtl/m68k_bus_master_if.sv
// m68k_bus_master_if: request handshake from internal logic plus the 68000 bus pins,
// with the bus-master view (master) and the requester/responder view (slave).
`default_nettype none

interface m68k_bus_master_if;
    logic        req;
    logic        req_rw;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_uds;
    logic        req_lds;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic        BUS_GRANT;
    logic        BUS_OE;
    logic [22:0] ADDR;
    logic        RW;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;
    logic [15:0] DATA_IN;
    logic        DTACK_n;

    modport master (
        input  req, req_rw, req_addr, req_wdata, req_uds, req_lds, BUS_GRANT, DATA_IN, DTACK_n,
        output ack, err, rdata, busy, BUS_OE, ADDR, RW, AS_n, UDS_n, LDS_n, DATA_OUT, DATA_OE
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata, req_uds, req_lds, BUS_GRANT, DATA_IN, DTACK_n,
        input  ack, err, rdata, busy, BUS_OE, ADDR, RW, AS_n, UDS_n, LDS_n, DATA_OUT, DATA_OE
    );
endinterface

`default_nettype wire

// File: rtl/m68k_bus_master_timeout.sv
// m68k_bus_timeout: counts consecutive WAIT cycles and flags expiry on the last permitted one.
`default_nettype none

module m68k_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_W          = 9
) (
    input  wire logic CLK,
    input  wire logic RESET_n,
    input  wire logic run_i,
    output logic      expired_o
);

    logic [TMO_W-1:0] cnt_q;

    // Held at zero outside WAIT, so each WAIT entry starts a fresh count.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= '0;
        end else if (!run_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = run_i && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: turns a one-word internal request into a full 68000 S0-S7 bus cycle.
// Define BUS_TIMEOUT_EN to terminate cycles that see no DTACK_n within TIMEOUT_CYCLES.
`default_nettype none

module m68k_bus_master
    import m68k_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMO_W          = 9
) (
    input  wire logic         CLK,
    input  wire logic         RESET_n,
    m68k_bus_master_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_timeout_width
        $error("TMO_W too narrow for TIMEOUT_CYCLES");
    end

    logic [2:0]  state_q, state_d;
    bus_req_t    req_q, req_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        data_oe_q, data_oe_d;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic        w_timeout;
    logic        w_as_on;
    logic        w_ds_on;

`ifdef BUS_TIMEOUT_EN
    m68k_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_timeout (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .run_i     (state_q == ST_WAIT),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req && bus.BUS_GRANT) begin
                    req_d.rw    = bus.req_rw;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    req_d.lanes = lane_mask(bus.req_uds, bus.req_lds);
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_STRB;
            ST_STRB: state_d = ST_WAIT;     // an early DTACK_n is deliberately not looked at here
            ST_WAIT: begin
                if (!bus.DTACK_n) begin
                    state_d = ST_DATA;
                end else if (w_timeout) begin
                    state_d = ST_TERM;
                end
            end
            ST_DATA: state_d = ST_TERM;
            ST_TERM: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so pins change on the edge only.
    always_comb begin
        w_as_on   = (state_d == ST_STRB) || (state_d == ST_WAIT) || (state_d == ST_DATA);
        w_ds_on   = req_d.rw ? w_as_on : ((state_d == ST_WAIT) || (state_d == ST_DATA));
        busy_d    = (state_d != ST_IDLE);
        data_oe_d = busy_d && !req_d.rw;
        as_n_d    = !w_as_on;
        uds_n_d   = !(w_ds_on && req_d.lanes[1]);
        lds_n_d   = !(w_ds_on && req_d.lanes[0]);
        ack_d     = (state_d == ST_TERM);
        err_d     = (state_q == ST_WAIT) && (state_d == ST_TERM);
        rdata_d   = rdata_q;
        if ((state_q == ST_DATA) && req_q.rw) begin
            rdata_d = bus.DATA_IN;
        end else if (err_d && req_q.rw) begin
            rdata_d = 16'hFFFF;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '{rw: 1'b1, addr: '0, wdata: '0, lanes: '0};
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            data_oe_q <= 1'b0;
            as_n_q    <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            data_oe_q <= data_oe_d;
            as_n_q    <= as_n_d;
            uds_n_q   <= uds_n_d;
            lds_n_q   <= lds_n_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.BUS_OE   = busy_q;
    assign bus.DATA_OE  = data_oe_q;
    assign bus.AS_n     = as_n_q;
    assign bus.UDS_n    = uds_n_q;
    assign bus.LDS_n    = lds_n_q;
    assign bus.ADDR     = req_q.addr;
    assign bus.RW       = req_q.rw;
    assign bus.DATA_OUT = req_q.wdata;

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: randomized bus cycles against a cycle-indexed model of the S0-S7 timing.
`default_nettype none

module tb_m68k_bus_master;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO   = 16;
    localparam int TMO_W = 5;
`else
    localparam int TMO   = 256;
    localparam int TMO_W = 9;
`endif
    localparam logic [7:0] IDLE_STATUS = 8'b0000_0111;

    logic CLK = 1'b0;
    logic RESET_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    m68k_bus_master_if bus ();

    m68k_bus_master #(
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (TMO_W)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ack, err, busy, BUS_OE, DATA_OE, AS_n, UDS_n, LDS_n}
    function automatic logic [7:0] status();
        return {bus.ack, bus.err, bus.busy, bus.BUS_OE, bus.DATA_OE, bus.AS_n, bus.UDS_n, bus.LDS_n};
    endfunction

    task automatic idle_inputs();
        bus.req       = 1'b0;
        bus.req_rw    = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_uds   = 1'b0;
        bus.req_lds   = 1'b0;
        bus.BUS_GRANT = 1'b1;
        bus.DATA_IN   = '0;
        bus.DTACK_n   = 1'b1;
    endtask

    // Cycle 0 holds the accepted request; phase k (1..) follows. Called and returns just after a negedge.
    task automatic bus_cycle(input logic rw, input logic [22:0] addr, input logic [15:0] wd,
                             input logic uds, input logic lds, input int waits, input bit early,
                             input int no_grant, input bit noise, input logic [15:0] rd);
        int   last;
        logic ue, le, as_low, ds_on, busy;
        last = 5 + waits;
        ue   = uds || !(uds || lds);
        le   = lds || !(uds || lds);
        bus.req = 1'b1;  bus.req_rw = rw;  bus.req_addr = addr;  bus.req_wdata = wd;
        bus.req_uds = uds;  bus.req_lds = lds;  bus.DTACK_n = 1'b1;
        bus.BUS_GRANT = (no_grant == 0);
        for (int i = 0; i < no_grant; i++) begin
            @(negedge CLK);
            check("nogrant_status", status(), IDLE_STATUS);
            if (i == no_grant - 1) bus.BUS_GRANT = 1'b1;
        end
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge CLK);
            busy   = (k <= last);
            as_low = (k >= 2) && (k <= last - 1);
            ds_on  = as_low && (rw || (k >= 3));
            check("status", status(),
                  {k == last, 1'b0, busy, busy, busy && !rw, !as_low, !(ds_on && ue), !(ds_on && le)});
            if (busy) begin
                check("addr", bus.ADDR, addr);
                check("rw", bus.RW, rw);
            end
            if (!rw) check("dout", bus.DATA_OUT, wd);
            if (k == last && rw) check("rdata", bus.rdata, rd);
            bus.DTACK_n = !(((k >= 3 + waits) && (k <= last - 1)) || (early && k == 2));
            bus.DATA_IN = (k == 4 + waits) ? rd : 16'($urandom);
            if (noise && k < last) begin
                bus.req       = 1'($urandom);
                bus.req_rw    = 1'($urandom);
                bus.req_addr  = 23'($urandom);
                bus.req_wdata = 16'($urandom);
                bus.BUS_GRANT = 1'($urandom);
            end else if (k == 1) begin
                bus.req = 1'b0;
            end
            if (k == last) begin
                bus.req       = 1'b0;
                bus.BUS_GRANT = 1'b1;
            end
        end
    endtask

    task automatic back_to_back();
        int   acks = 0;
        int   high_run = 99;
        logic prev_as = 1'b1;
        bus.req = 1'b1;  bus.req_rw = 1'b1;  bus.req_addr = 23'h00_1000;
        bus.req_uds = 1'b0;  bus.req_lds = 1'b0;  bus.BUS_GRANT = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge CLK);
            check("b2b_ack", bus.ack, (k <= 17) && (k % 6 == 5));
            if (bus.ack) acks++;
            if (bus.AS_n) begin
                high_run++;
            end else begin
                if (prev_as) check("b2b_as_gap", high_run >= 2, 1'b1);
                high_run = 0;
            end
            prev_as     = bus.AS_n;
            bus.DTACK_n = bus.AS_n;
            if (k == 17) bus.req = 1'b0;
        end
        check("b2b_ack_count", acks, 3);
        bus.DTACK_n = 1'b1;
    endtask

    task automatic reset_midcycle();
        int acks = 0;
        bus.req = 1'b1;  bus.req_rw = 1'b1;  bus.req_addr = 23'h2A_5A5A;
        bus.BUS_GRANT = 1'b1;  bus.DTACK_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            bus.req = 1'b0;
        end
        check("rst_pre_as", bus.AS_n, 1'b0);
        #2 RESET_n = 1'b0;
        #1;
        check("rst_async_status", status(), IDLE_STATUS);
        check("rst_async_addr", bus.ADDR, 23'h0);
        check("rst_async_rw", bus.RW, 1'b1);
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            if (bus.ack) acks++;
        end
        check("rst_no_ack", acks, 0);
        check("rst_idle", status(), IDLE_STATUS);
    endtask

    task automatic timeout_test();
        int acks = 0;
        bus.req = 1'b1;  bus.req_rw = 1'b1;  bus.req_addr = 23'h11_2233;
        bus.req_uds = 1'b1;  bus.req_lds = 1'b1;  bus.BUS_GRANT = 1'b1;  bus.DTACK_n = 1'b1;
`ifdef BUS_TIMEOUT_EN
        for (int k = 1; k <= TMO + 4; k++) begin
            @(negedge CLK);
            bus.req = 1'b0;
            check("tmo_ack_err", {bus.ack, bus.err}, (k == 3 + TMO) ? 2'b11 : 2'b00);
            check("tmo_as", bus.AS_n, !((k >= 2) && (k <= 2 + TMO)));
            if (k == 3 + TMO) check("tmo_rdata", bus.rdata, 16'hFFFF);
        end
        check("tmo_busy_end", bus.busy, 1'b0);
`else
        for (int k = 1; k <= 1000; k++) begin
            @(negedge CLK);
            bus.req = 1'b0;
            if (bus.ack || bus.err) acks++;
        end
        check("hang_no_ack", acks, 0);
        check("hang_as", bus.AS_n, 1'b0);
        check("hang_busy", bus.busy, 1'b1);
        RESET_n = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        check("hang_recover", status(), IDLE_STATUS);
`endif
    endtask

    initial begin
        RESET_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge CLK);
        check("reset_status", status(), IDLE_STATUS);
        check("reset_rdata", bus.rdata, 16'h0);
        check("reset_addr", bus.ADDR, 23'h0);
        check("reset_rw", bus.RW, 1'b1);
        check("reset_dout", bus.DATA_OUT, 16'h0);
        RESET_n = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", status(), IDLE_STATUS);

        bus_cycle(1'b1, 23'h3D_0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 16'h1234);
        bus_cycle(1'b0, 23'h01_2345, 16'hBEEF, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 16'h0000);
        bus_cycle(1'b1, 23'h40_0001, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 4, 1'b1, 16'hA55A);

        for (int t = 0; t < 30; t++) begin
            bus_cycle(1'($urandom), 23'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 2)),
                      1'($urandom), 16'($urandom));
        end

        back_to_back();
        reset_midcycle();
        bus_cycle(1'b0, 23'h7F_FFFF, 16'h5AA5, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 16'h0000);
        timeout_test();
        bus_cycle(1'b1, 23'h00_0000, 16'h0000, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 16'hC0DE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
